// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared processor definitions: fetch FSM states and default bus widths.
package inst_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [DATA_W_DEF-1:0] HALT_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : inst_fetch_ctrl_pkg

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and
// registers each fetched word into a one-entry valid/ready slot.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W    = ADDR_W_DEF,
    parameter int unsigned        DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] addr_ROM,
    input  logic [DATA_W-1:0] d_ROM,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic              capture_c;
    logic              is_halt_c;

    assign addr_ROM  = pc_q;
    assign is_halt_c = (d_ROM == HALT_WORD);

    // Next-state and capture decision; redirect overrides everything.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!redirect && (!instr_valid || instr_ready)) begin
                    capture_c = 1'b1;
                    if (is_halt_c) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (redirect) begin
                    state_d = en ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A redirect while running/idle only follows en; it never halts.
        if (redirect && state_q != HALT) begin
            state_d = en ? RUN : IDLE;
        end
    end

    // State register with halted mirroring the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= (state_d == HALT);
        end
    end

    // PC and output slot: redirect flush, capture, or handshake drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect) begin
            pc_q        <= redirect_pc;
            instr_valid <= 1'b0;
        end else if (capture_c) begin
            instr       <= d_ROM;
            instr_pc    <= pc_q;
            instr_valid <= 1'b1;
            pc_q        <= pc_q + ADDR_W'(1);
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule : inst_fetch_ctrl

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl with a bench-side ROM and model.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  addr_ROM;
    logic [31:0] d_ROM;
    logic [31:0] instr;
    logic [3:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [3:0]  redirect_pc;
    logic        halted;

    logic [31:0] rom [16];

    int errors = 0;
    int checks = 0;

    inst_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .addr_ROM    (addr_ROM),
        .d_ROM       (d_ROM),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    assign d_ROM = rom[addr_ROM];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rom[0]  = 32'h0041_0002; rom[1]  = 32'h0022_0006;
        rom[2]  = 32'h0822_0002; rom[3]  = 32'h0000_0005;
        rom[4]  = 32'h0000_0011; rom[5]  = 32'h0000_0012;
        rom[6]  = 32'h0000_0013; rom[7]  = 32'h0000_0014;
        rom[8]  = 32'h0000_0015; rom[9]  = 32'h0000_000A;
        rom[10] = 32'h0000_0016; rom[11] = 32'h0000_0017;
        rom[12] = 32'h0000_0018; rom[13] = 32'h0000_0019;
        rom[14] = 32'h0000_0000; rom[15] = 32'h0000_0001;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: PC, one-slot buffer, running/halted flags.
    int          m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    int          m_ipc;
    logic        m_run;
    logic        m_halt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_run = 0; m_halt = 0;
        end else if (redirect) begin
            m_pc = int'(redirect_pc); m_valid = 0; m_halt = 0; m_run = en;
        end else if (m_run && en && (!m_valid || instr_ready)) begin
            m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % 16;
            if (m_instr == 32'h0) begin
                m_halt = 1; m_run = 0;
            end
        end else begin
            if (m_valid && instr_ready) m_valid = 0;
            if (!m_halt) m_run = en;
        end
    end

    // Every-cycle comparison against the model, just after the edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("m_addr",   32'(addr_ROM),    32'(m_pc));
            check("m_valid",  32'(instr_valid), 32'(m_valid));
            check("m_halted", 32'(halted),      32'(m_halt));
            if (m_valid) begin
                check("m_instr", instr,          m_instr);
                check("m_ipc",   32'(instr_pc),  32'(m_ipc));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_slot(input string name, input logic v, input int pc, input logic [31:0] w);
        check({name, "_valid"}, 32'(instr_valid), 32'(v));
        if (v) begin
            check({name, "_pc"},    32'(instr_pc), 32'(pc));
            check({name, "_instr"}, instr,         w);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 4'd0;
        step(); step();
        check("rst_addr",   32'(addr_ROM),    32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_instr",  instr,            32'd0);
        check("rst_ipc",    32'(instr_pc),    32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        rst = 1'b0;
        step();
        check("idle_valid", 32'(instr_valid), 32'd0);

        // Start-up and streaming
        en = 1'b1; instr_ready = 1'b1;
        step();
        expect_slot("start", 1'b0, 0, 32'h0);
        step(); expect_slot("d0", 1'b1, 0, 32'h0041_0002);
        step(); expect_slot("d1", 1'b1, 1, 32'h0022_0006);
        step(); expect_slot("d2", 1'b1, 2, 32'h0822_0002);
        step(); expect_slot("d3", 1'b1, 3, 32'h0000_0005);

        // Backpressure while pc 1 is held
        redirect = 1'b1; redirect_pc = 4'd0;
        step(); redirect = 1'b0;
        expect_slot("rd0", 1'b0, 0, 32'h0);
        step(); expect_slot("bp0", 1'b1, 0, 32'h0041_0002);
        step(); expect_slot("bp1", 1'b1, 1, 32'h0022_0006);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_slot("stall", 1'b1, 1, 32'h0022_0006);
            check("stall_addr", 32'(addr_ROM), 32'd2);
        end
        instr_ready = 1'b1;
        step(); expect_slot("bp2", 1'b1, 2, 32'h0822_0002);

        // Redirect drops a pending word
        instr_ready = 1'b0;
        step(); expect_slot("pend", 1'b1, 2, 32'h0822_0002);
        redirect = 1'b1; redirect_pc = 4'd9;
        step(); redirect = 1'b0; instr_ready = 1'b1;
        expect_slot("flush", 1'b0, 0, 32'h0);
        check("flush_addr", 32'(addr_ROM), 32'd9);
        step(); expect_slot("tgt9", 1'b1, 9, 32'h0000_000A);

        // Free run to the halt word at pc 14
        redirect = 1'b1; redirect_pc = 4'd0;
        step(); redirect = 1'b0;
        begin
            int n = 0;
            while (!(instr_valid && instr_pc == 4'd14) && n < 40) begin
                step(); n++;
            end
            check("halt_reached", 32'(n < 40), 32'd1);
        end
        expect_slot("halt_word", 1'b1, 14, 32'h0);
        check("halted_now", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_valid",  32'(instr_valid), 32'd0);
            check("halt_addr",   32'(addr_ROM),    32'd15);
            check("halt_halted", 32'(halted),      32'd1);
        end
        redirect = 1'b1; redirect_pc = 4'd15;
        step(); redirect = 1'b0;
        check("resume_halted", 32'(halted), 32'd0);
        step(); expect_slot("d15",  1'b1, 15, 32'h0000_0001);
        step(); expect_slot("wrap", 1'b1, 0,  32'h0041_0002);

        // Drop en with a pending stall, then asynchronous reset
        en = 1'b0; instr_ready = 1'b0;
        step(); expect_slot("en0_a", 1'b1, 0, 32'h0041_0002);
        check("en0_addr", 32'(addr_ROM), 32'd1);
        step(); expect_slot("en0_b", 1'b1, 0, 32'h0041_0002);
        #2 rst = 1'b1;
        #1;
        check("arst_valid",  32'(instr_valid), 32'd0);
        check("arst_addr",   32'(addr_ROM),    32'd0);
        check("arst_instr",  instr,            32'd0);
        check("arst_halted", 32'(halted),      32'd0);
        step(); step();
        rst = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("noen_valid", 32'(instr_valid), 32'd0);
            check("noen_addr",  32'(addr_ROM),    32'd0);
        end
        en = 1'b1;
        step(); step();
        expect_slot("restart", 1'b1, 0, 32'h0041_0002);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_inst_fetch_ctrl

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch sequencer for the processor's 16-word combinational instruction ROM. It owns the program counter and drives the ROM address. Each fetched word is registered into a one-entry valid/ready output slot for the decode stage. It also handles branch redirects and a halt word that stops fetching.

## Interface
Parameters:
- ADDR_W, 4: ROM address / PC width.
- DATA_W, 32: instruction width.
- RESET_PC, 4'h0: PC value loaded on reset.
- HALT_WORD, 32'h0000_0000: instruction encoding that stops fetch after delivery.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; fetch proceeds only while high.
- addr_ROM  out  ADDR_W  ROM address; equals the PC register.
- d_ROM  in  DATA_W  combinational ROM data for addr_ROM.
- instr  out  DATA_W  registered instruction.
- instr_pc  out  ADDR_W  address the instruction was fetched from.
- instr_valid  out  1  output slot holds an instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect  in  1  load redirect_pc and flush the output slot.
- redirect_pc  in  ADDR_W  branch/jump target.
- halted  out  1  FSM is in HALT.

## Operation
- State encoding: IDLE, RUN, HALT. Reset state is IDLE.
- Reset values:
  - pc = addr_ROM = RESET_PC.
  - instr = 0, instr_pc = 0.
  - instr_valid = 0, halted = 0.
- Capture condition: state == RUN, redirect == 0, and (!instr_valid || instr_ready).
- On capture:
  - instr <= d_ROM, instr_pc <= pc, instr_valid <= 1.
  - pc <= pc + 1, modulo 2^ADDR_W, so 15 wraps to 0.
- Handshake without a new capture: instr_valid && instr_ready clears instr_valid.
- Stall: while instr_valid && !instr_ready, instr and instr_pc hold stable and pc holds.
- Redirect has highest priority and acts in any state:
  - pc <= redirect_pc, instr_valid <= 0; a pending, unaccepted instruction is dropped.
  - A simultaneous handshake still counts as accepted.
  - No capture occurs in a redirect cycle.
- State transitions:
  - IDLE -> RUN when en = 1.
  - RUN -> IDLE when en = 0. No new capture; the pending slot drains normally.
  - RUN -> HALT on a capture where d_ROM == HALT_WORD. The halt word itself is delivered; pc has already advanced.
  - HALT -> RUN on redirect with en = 1.
  - HALT -> IDLE on redirect with en = 0.
  - HALT otherwise persists regardless of en.
- halted = (state == HALT), registered.

## Timing
- Fetch latency: 1 cycle from addr_ROM = A to instr_valid with instr_pc = A.
- Throughput: 1 instruction/cycle while instr_ready stays high.
- Redirect:
  - Cycle N: redirect asserted.
  - Cycle N+1: addr_ROM = target, instr_valid = 0.
  - Cycle N+2: target instruction valid.
- Start-up: en rises in cycle N; state is RUN in N+1; first instr_valid in N+2.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), independent of clk. Fetch restarts from RESET_PC only after en is seen high in IDLE.
- addr_ROM changes only on clock edges and reset; it is never combinationally derived from inputs.

## Structure
- Shared processor package/header holds:
  - the FSM state constants (IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2);
  - the HALT_WORD default;
  - ADDR_W and DATA_W defaults, shared with the ROM and decode stage.
- Single flat module; no sub-module. The ROM is instantiated beside it at the top level, not inside it.

## Test plan
- Reset, en = 1, instr_ready = 1: consecutive deliveries are
  - pc 0 → 0x00410002;
  - pc 1 → 0x00220006;
  - pc 2 → 0x08220002;
  - pc 3 → 0x00000005.
- Backpressure: instr_ready low for 3 cycles while pc 1 is held. Required: instr stays 0x00220006 and addr_ROM stays 2. pc 2 is delivered on the cycle after ready returns.
- Redirect to 9 while an unaccepted instruction is pending:
  - the pending word is dropped;
  - instr_valid = 0 for 1 cycle;
  - next delivery is pc 9 → 0x0000000A.
- Free run from 0: pc 14 delivers 0x00000000, halted = 1 next cycle, instr_valid clears after acceptance, addr_ROM stays 15. A redirect to 15 with en = 1 resumes: pc 15 → 0x00000001, then wrap to pc 0.
- Drop en mid-run, then assert rst mid-stall. Required:
  - en = 0: no new captures;
  - rst: instr_valid = 0 and addr_ROM = 0 immediately, without a clock edge;
  - no fetch until en is raised again.
